apb_slave_multi: RTL

APB_SLAVE_MULTI -- requirements
Module: apb_slave_multi

---
 rtl/apb_slave_multi.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/apb_slave_multi.sv
// APB slave bridging one requester to NUM_REGIONS register-file targets selected by an address field.
// Every output is registered; a zero-wait target costs one APB wait state, and a decode error completes at once.
module apb_slave_multi #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_REGIONS = 4,
  parameter int REGION_LSB  = 12,
  parameter int TIMEOUT     = 16
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic                              PSELx,
  input  logic                              PENABLE,
  input  logic                              PWRITE,
  input  logic [ADDR_WIDTH-1:0]             PADDR,
  input  logic [DATA_WIDTH-1:0]             PWDATA,
  input  logic [STRB_WIDTH-1:0]             PSTRB,
  output logic                              PREADY,
  output logic                              PSLVERR,
  output logic [DATA_WIDTH-1:0]             PRDATA,
  output logic [NUM_REGIONS-1:0]            RegSEL,
  output logic                              RegENABLE,
  output logic                              RegWRITE,
  output logic [ADDR_WIDTH-1:0]             RegADDR,
  output logic [DATA_WIDTH-1:0]             RegWDATA,
  output logic [STRB_WIDTH-1:0]             RegSTRB,
  input  logic [NUM_REGIONS-1:0]            RegREADY,
  input  logic [NUM_REGIONS-1:0]            RegSLVERR,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] RegRDATA
);

  localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int NW = 1 << RW;
  // Bit i set when region code i maps to an existing target.
  localparam logic [NW-1:0]         REGION_OK  = {NW{1'b1}} >> (NW - NUM_REGIONS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [7:0]            WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                  r_state;
  logic [7:0]              r_wait;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [DATA_WIDTH-1:0]   r_prdata;
  logic [NUM_REGIONS-1:0]  r_reg_sel;
  logic                    r_reg_en;
  logic                    r_reg_write;
  logic [ADDR_WIDTH-1:0]   r_reg_addr;
  logic [DATA_WIDTH-1:0]   r_reg_wdata;
  logic [STRB_WIDTH-1:0]   r_reg_strb;

  logic [RW-1:0]           w_region;
  logic                    w_err;
  logic [NUM_REGIONS-1:0]  w_onehot;
  logic                    w_ready;
  logic                    w_slverr;
  logic                    w_req_exit;
  logic [DATA_WIDTH-1:0]   w_rdata;

  assign w_region = PADDR[REGION_LSB +: RW];
  assign w_err    = (|(PADDR & ALIGN_MASK)) | ~REGION_OK[w_region] | (~PWRITE & (|PSTRB));
  assign w_onehot = NUM_REGIONS'(1) << w_region;

  // The registered one-hot select masks off responses from every other target.
  assign w_ready    = |(RegREADY & r_reg_sel);
  assign w_slverr   = |(RegSLVERR & r_reg_sel);
  assign w_req_exit = !PSELx || w_ready || (r_wait == WAIT_LAST);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_reg_sel[i]) w_rdata = w_rdata | RegRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_prdata    <= '0;
      r_reg_sel   <= '0;
      r_reg_en    <= 1'b0;
      r_reg_write <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_strb  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait <= '0;
          if (PSELx && !PENABLE) begin
            if (w_err) begin
              r_state   <= S_DONE;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_prdata  <= '0;
            end else begin
              r_state     <= S_REQ;
              r_reg_sel   <= w_onehot;
              r_reg_en    <= 1'b1;
              r_reg_write <= PWRITE;
              r_reg_addr  <= PADDR;
              r_reg_wdata <= PWRITE ? PWDATA : '0;
              r_reg_strb  <= PWRITE ? PSTRB : '0;
            end
          end
        end
        S_REQ: begin
          if (w_req_exit) begin
            r_reg_sel   <= '0;
            r_reg_en    <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_strb  <= '0;
          end
          // Abort wins over completion so no PREADY is issued to a departed requester.
          if (!PSELx) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
          end else if (w_ready) begin
            r_state   <= S_DONE;
            r_pready  <= 1'b1;
            r_pslverr <= w_slverr;
            r_prdata  <= r_reg_write ? '0 : w_rdata;
          end else if (r_wait == WAIT_LAST) begin
            r_state   <= S_DONE;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            r_prdata  <= '0;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_wait    <= '0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign PREADY    = r_pready;
  assign PSLVERR   = r_pslverr;
  assign PRDATA    = r_prdata;
  assign RegSEL    = r_reg_sel;
  assign RegENABLE = r_reg_en;
  assign RegWRITE  = r_reg_write;
  assign RegADDR   = r_reg_addr;
  assign RegWDATA  = r_reg_wdata;
  assign RegSTRB   = r_reg_strb;

endmodule
